// File: rtl/mig_app_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the MIG DDR3 app_* interface.
// One transaction is issued at a time; read return data is routed back to the
// issuing requester through an in-order tag FIFO.
module mig_app_arbiter #(
    parameter int addr_width_p      = 28,
    parameter int data_width_p      = 128,
    parameter int mask_width_p      = data_width_p / 8,
    parameter int max_outstanding_p = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      init_calib_complete_i,

    input  logic [1:0]                req_v_i,
    input  logic [1:0]                req_we_i,
    input  logic [2*addr_width_p-1:0] req_addr_i,
    input  logic [2*data_width_p-1:0] req_data_i,
    input  logic [2*mask_width_p-1:0] req_mask_i,
    output logic [1:0]                req_ready_o,

    output logic [1:0]                resp_v_o,
    output logic [data_width_p-1:0]   resp_data_o,

    output logic [addr_width_p-1:0]   app_addr_o,
    output logic [2:0]                app_cmd_o,
    output logic                      app_en_o,
    input  logic                      app_rdy_i,
    output logic [data_width_p-1:0]   app_wdf_data_o,
    output logic [mask_width_p-1:0]   app_wdf_mask_o,
    output logic                      app_wdf_wren_o,
    output logic                      app_wdf_end_o,
    input  logic                      app_wdf_rdy_i,
    input  logic [data_width_p-1:0]   app_rd_data_i,
    input  logic                      app_rd_data_valid_i
);

    localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

    localparam logic [2:0] cmd_write_lp = 3'b000;
    localparam logic [2:0] cmd_read_lp  = 3'b001;

    typedef enum logic [1:0] {e_calib, e_idle, e_issue} state_e;

    state_e state_q, state_d;

    // issue registers
    logic [2:0]              cmd_q;
    logic                    we_q;
    logic [addr_width_p-1:0] addr_q;
    logic [data_width_p-1:0] data_q;
    logic [mask_width_p-1:0] mask_q;
    logic                    id_q;
    logic                    cmd_done_q;
    logic                    data_done_q;
    logic                    last_grant_q;

    // tag FIFO
    logic [max_outstanding_p-1:0] tag_mem_q;
    logic [ptr_w_lp-1:0]          wr_ptr_q, rd_ptr_q;
    logic [cnt_w_lp-1:0]          tag_count_q;

    logic [1:0] elig;
    logic       tag_room, tag_empty;
    logic       grant_v, gnt_id;
    logic       cmd_acc, data_acc, issue_done;
    logic       push, pop, head_id;

    assign tag_room  = tag_count_q < cnt_w_lp'(max_outstanding_p);
    assign tag_empty = (tag_count_q == '0);
    assign elig      = req_v_i & (req_we_i | {2{tag_room}});

    // Tie goes to the requester not granted last; a lone eligible requester always wins.
    assign gnt_id  = (elig == 2'b11) ? ~last_grant_q : elig[1];
    assign grant_v = (state_q == e_idle) & init_calib_complete_i & (|elig);

    assign cmd_acc    = app_en_o & app_rdy_i;
    assign data_acc   = app_wdf_wren_o & app_wdf_rdy_i;
    assign issue_done = (cmd_done_q | cmd_acc) & (data_done_q | data_acc);

    assign push    = cmd_acc & (cmd_q == cmd_read_lp);
    assign pop     = app_rd_data_valid_i & ~tag_empty;
    assign head_id = tag_mem_q[rd_ptr_q];

    // state register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= e_calib;
        else         state_q <= state_d;
    end

    // next-state: a transaction in flight always completes before calibration loss takes effect
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_calib: if (init_calib_complete_i) state_d = e_idle;
            e_idle: begin
                if (!init_calib_complete_i) state_d = e_calib;
                else if (grant_v)           state_d = e_issue;
            end
            e_issue: if (issue_done) state_d = init_calib_complete_i ? e_idle : e_calib;
            default: state_d = e_calib;
        endcase
    end

    // outputs: grant is combinational in e_idle, channel enables come from the done flags
    always_comb begin
        req_ready_o    = 2'b00;
        app_en_o       = 1'b0;
        app_wdf_wren_o = 1'b0;
        if (grant_v) req_ready_o = gnt_id ? 2'b10 : 2'b01;
        if (state_q == e_issue) begin
            app_en_o       = ~cmd_done_q;
            app_wdf_wren_o = we_q & ~data_done_q;
        end
    end

    assign app_wdf_end_o  = app_wdf_wren_o;
    assign app_addr_o     = addr_q;
    assign app_cmd_o      = cmd_q;
    assign app_wdf_data_o = data_q;
    assign app_wdf_mask_o = mask_q;

    // capture the granted request and track command/data channel acceptance
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmd_q        <= cmd_write_lp;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            id_q         <= 1'b0;
            cmd_done_q   <= 1'b0;
            data_done_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (grant_v) begin
            cmd_q        <= req_we_i[gnt_id] ? cmd_write_lp : cmd_read_lp;
            we_q         <= req_we_i[gnt_id];
            addr_q       <= req_addr_i[gnt_id*addr_width_p +: addr_width_p];
            data_q       <= req_data_i[gnt_id*data_width_p +: data_width_p];
            mask_q       <= req_mask_i[gnt_id*mask_width_p +: mask_width_p];
            id_q         <= gnt_id;
            cmd_done_q   <= 1'b0;
            data_done_q  <= ~req_we_i[gnt_id];
            last_grant_q <= gnt_id;
        end else begin
            if (cmd_acc)  cmd_done_q  <= 1'b1;
            if (data_acc) data_done_q <= 1'b1;
        end
    end

    // tag FIFO: one requester id per accepted read command, popped by returning data
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_mem_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_count_q <= '0;
        end else begin
            if (push) begin
                tag_mem_q[wr_ptr_q] <= id_q;
                wr_ptr_q <= (wr_ptr_q == ptr_w_lp'(max_outstanding_p-1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= (rd_ptr_q == ptr_w_lp'(max_outstanding_p-1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   tag_count_q <= tag_count_q + 1'b1;
                2'b01:   tag_count_q <= tag_count_q - 1'b1;
                default: tag_count_q <= tag_count_q;
            endcase
        end
    end

    // read data goes to the oldest outstanding tag; nothing outstanding means it is dropped
    always_comb begin
        resp_v_o = 2'b00;
        if (pop) resp_v_o = head_id ? 2'b10 : 2'b01;
    end
    assign resp_data_o = app_rd_data_i;

`ifndef SYNTHESIS
    // flag read data the controller returned without a matching outstanding read
    always_ff @(posedge clk_i) begin
        if (!reset_i && app_rd_data_valid_i && tag_empty)
            $warning("mig_app_arbiter: read data with no outstanding tag dropped");
    end
`endif

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Directed bench for mig_app_arbiter: calibration gate, write sequencing,
// round-robin, tag-FIFO full/push-pop behaviour and mid-issue reset.
module tb_mig_app_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          init_calib_complete_i;
    logic [1:0]    req_v_i, req_we_i;
    logic [2*AW-1:0] req_addr_i;
    logic [2*DW-1:0] req_data_i;
    logic [2*MW-1:0] req_mask_i;
    logic [1:0]    req_ready_o, resp_v_o;
    logic [DW-1:0] resp_data_o;
    logic [AW-1:0] app_addr_o;
    logic [2:0]    app_cmd_o;
    logic          app_en_o, app_rdy_i;
    logic [DW-1:0] app_wdf_data_o;
    logic [MW-1:0] app_wdf_mask_o;
    logic          app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
    logic [DW-1:0] app_rd_data_i;
    logic          app_rd_data_valid_i;

    int errors = 0;
    int checks = 0;

    mig_app_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i), .init_calib_complete_i(init_calib_complete_i),
        .req_v_i(req_v_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_mask_i(req_mask_i), .req_ready_o(req_ready_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
        .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
        .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
        .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_i(app_rd_data_i), .app_rd_data_valid_i(app_rd_data_valid_i)
    );

    always #5 clk_i = ~clk_i;

    // advance one cycle; inputs driven after this land at the next rising edge
    task automatic tick;
        @(posedge clk_i);
        #2;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        repeat (3) tick();
        #1;
        checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL reset ready: got %b want 00", req_ready_o); end
        checks++; if (resp_v_o !== 2'b00) begin errors++; $display("FAIL reset resp_v: got %b want 00", resp_v_o); end
        checks++; if (app_en_o !== 1'b0) begin errors++; $display("FAIL reset app_en: got %b want 0", app_en_o); end
        checks++; if ({app_wdf_wren_o, app_wdf_end_o} !== 2'b00) begin errors++; $display("FAIL reset wren/end: got %b want 00", {app_wdf_wren_o, app_wdf_end_o}); end
        checks++; if (app_cmd_o !== 3'b000) begin errors++; $display("FAIL reset cmd: got %b want 000", app_cmd_o); end
        checks++; if (app_addr_o !== '0) begin errors++; $display("FAIL reset addr: got %h want 0", app_addr_o); end
        checks++; if (dut.tag_count_q !== 4'd0) begin errors++; $display("FAIL reset count: got %0d want 0", dut.tag_count_q); end
        app_rd_data_valid_i = 1'b1;
        #1;
        checks++; if (resp_v_o !== 2'b00) begin errors++; $display("FAIL reset rdvalid drop: got %b want 00", resp_v_o); end
        app_rd_data_valid_i = 1'b0;
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_calib;
        int bad;
        bad = 0;
        req_v_i = 2'b01; req_we_i = 2'b00; req_addr_i[0 +: AW] = 28'h40; app_rdy_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL calib gate cycle %0d: got %b want 00", i, req_ready_o); end
        end
        init_calib_complete_i = 1'b1;
        tick();
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL calib first grant: got %b want 01", req_ready_o); end
        tick();
        checks++; if ({app_en_o, app_cmd_o} !== 4'b1001) begin errors++; $display("FAIL calib issue en/cmd: got %b want 1001", {app_en_o, app_cmd_o}); end
        checks++; if (app_addr_o !== 28'h40) begin errors++; $display("FAIL calib issue addr: got %h want 40", app_addr_o); end
        checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL calib ready in issue: got %b want 00", req_ready_o); end
        req_v_i = 2'b00; app_rdy_i = 1'b1;
        tick();
        checks++; if (app_en_o !== 1'b0) begin errors++; $display("FAIL calib en after accept: got %b want 0", app_en_o); end
        checks++; if (dut.tag_count_q !== 4'd1) begin errors++; $display("FAIL calib count: got %0d want 1", dut.tag_count_q); end
        app_rd_data_valid_i = 1'b1; app_rd_data_i = 128'hDEAD;
        #1;
        checks++; if (resp_v_o !== 2'b01) begin errors++; $display("FAIL calib resp_v: got %b want 01", resp_v_o); end
        checks++; if (resp_data_o !== 128'hDEAD) begin errors++; $display("FAIL calib resp_data: got %h want dead", resp_data_o); end
        tick();
        app_rd_data_valid_i = 1'b0;
        checks++; if (dut.tag_count_q !== 4'd0) begin errors++; $display("FAIL calib count drain: got %0d want 0", dut.tag_count_q); end
    endtask

    task automatic test_write;
        logic [DW-1:0] wdata;
        wdata = {16{8'hA5}};
        req_addr_i[0 +: AW] = 28'h100; req_data_i[0 +: DW] = wdata; req_mask_i[0 +: MW] = '0;
        req_we_i = 2'b01; req_v_i = 2'b01; app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL write grant: got %b want 01", req_ready_o); end
        tick();
        req_v_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({app_en_o, app_cmd_o} !== 4'b1000) begin errors++; $display("FAIL write en/cmd cycle %0d: got %b want 1000", i, {app_en_o, app_cmd_o}); end
            checks++; if (app_addr_o !== 28'h100) begin errors++; $display("FAIL write addr cycle %0d: got %h want 100", i, app_addr_o); end
            checks++; if ({app_wdf_wren_o, app_wdf_end_o} !== {2{i == 0}}) begin errors++; $display("FAIL write wren/end cycle %0d: got %b want %b", i, {app_wdf_wren_o, app_wdf_end_o}, {2{i == 0}}); end
            if (i == 0) begin
                checks++; if ({app_wdf_data_o, app_wdf_mask_o} !== {wdata, 16'h0}) begin errors++; $display("FAIL write data/mask: got %h/%h want %h/0", app_wdf_data_o, app_wdf_mask_o, wdata); end
            end
            if (i == 3) app_rdy_i = 1'b1;
            tick();
        end
        checks++; if ({app_en_o, app_wdf_wren_o} !== 2'b00) begin errors++; $display("FAIL write done en/wren: got %b want 00", {app_en_o, app_wdf_wren_o}); end
        checks++; if (dut.tag_count_q !== 4'd0) begin errors++; $display("FAIL write count: got %0d want 0", dut.tag_count_q); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_id;
        exp_id = 4'b0101;  // k=0..3 -> 1,0,1,0 (last grant was requester 0)
        req_v_i = 2'b11; req_we_i = 2'b00;
        req_addr_i[0 +: AW] = 28'h200; req_addr_i[AW +: AW] = 28'h300;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (req_ready_o !== (exp_id[k] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr grant %0d: got %b want %b", k, req_ready_o, exp_id[k] ? 2'b10 : 2'b01); end
            tick();
            checks++; if (app_addr_o !== (exp_id[k] ? 28'h300 : 28'h200)) begin errors++; $display("FAIL rr addr %0d: got %h", k, app_addr_o); end
            tick();
        end
        req_v_i = 2'b00;
        checks++; if (dut.tag_count_q !== 4'd4) begin errors++; $display("FAIL rr count: got %0d want 4", dut.tag_count_q); end
        for (int k = 0; k < 4; k++) begin
            app_rd_data_valid_i = 1'b1; app_rd_data_i = DW'(k + 16);
            #1;
            checks++; if (resp_v_o !== (exp_id[k] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr resp %0d: got %b want %b", k, resp_v_o, exp_id[k] ? 2'b10 : 2'b01); end
            tick();
        end
        app_rd_data_valid_i = 1'b0;
    endtask

    task automatic test_tag_full;
        req_v_i = 2'b10; req_we_i = 2'b00; req_addr_i[AW +: AW] = 28'h400;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL full fill grant %0d: got %b want 10", k, req_ready_o); end
            tick();
            tick();
        end
        checks++; if (dut.tag_count_q !== 4'd8) begin errors++; $display("FAIL full count: got %0d want 8", dut.tag_count_q); end
        req_v_i = 2'b11; req_we_i = 2'b01; req_addr_i[0 +: AW] = 28'h480;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL full write grant: got %b want 01", req_ready_o); end
        tick();
        tick();
        req_v_i = 2'b10;
        app_rd_data_valid_i = 1'b1; app_rd_data_i = 128'h77;
        #1;
        checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL full read blocked: got %b want 00", req_ready_o); end
        checks++; if (resp_v_o !== 2'b10) begin errors++; $display("FAIL full resp: got %b want 10", resp_v_o); end
        tick();
        app_rd_data_valid_i = 1'b0;
        #1;
        checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL full resume grant: got %b want 10", req_ready_o); end
        tick();
        tick();
        req_v_i = 2'b00;
        checks++; if (dut.tag_count_q !== 4'd8) begin errors++; $display("FAIL full refill count: got %0d want 8", dut.tag_count_q); end
        for (int k = 0; k < 5; k++) begin
            app_rd_data_valid_i = 1'b1;
            #1;
            checks++; if (resp_v_o !== 2'b10) begin errors++; $display("FAIL full drain %0d: got %b want 10", k, resp_v_o); end
            tick();
        end
        app_rd_data_valid_i = 1'b0;
        checks++; if (dut.tag_count_q !== 4'd3) begin errors++; $display("FAIL full drained count: got %0d want 3", dut.tag_count_q); end
    endtask

    task automatic test_push_pop;
        logic [2:0] exp_id;
        exp_id = 3'b011;  // remaining tags oldest first: 1,1,0
        req_v_i = 2'b01; req_we_i = 2'b00; req_addr_i[0 +: AW] = 28'h500;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL pp grant: got %b want 01", req_ready_o); end
        tick();
        req_v_i = 2'b00;
        app_rd_data_valid_i = 1'b1; app_rd_data_i = 128'hBEEF;
        #1;
        checks++; if (app_en_o !== 1'b1) begin errors++; $display("FAIL pp en: got %b want 1", app_en_o); end
        checks++; if (resp_v_o !== 2'b10) begin errors++; $display("FAIL pp resp: got %b want 10", resp_v_o); end
        checks++; if (resp_data_o !== 128'hBEEF) begin errors++; $display("FAIL pp data: got %h want beef", resp_data_o); end
        tick();
        app_rd_data_valid_i = 1'b0;
        checks++; if (dut.tag_count_q !== 4'd3) begin errors++; $display("FAIL pp count: got %0d want 3", dut.tag_count_q); end
        for (int k = 0; k < 3; k++) begin
            app_rd_data_valid_i = 1'b1;
            #1;
            checks++; if (resp_v_o !== (exp_id[k] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL pp drain %0d: got %b want %b", k, resp_v_o, exp_id[k] ? 2'b10 : 2'b01); end
            tick();
        end
        app_rd_data_valid_i = 1'b0;
        checks++; if (dut.tag_count_q !== 4'd0) begin errors++; $display("FAIL pp final count: got %0d want 0", dut.tag_count_q); end
    endtask

    task automatic test_reset_mid;
        req_v_i = 2'b01; req_we_i = 2'b00; req_addr_i[0 +: AW] = 28'h600; app_rdy_i = 1'b1;
        tick();
        tick();
        checks++; if (dut.tag_count_q !== 4'd1) begin errors++; $display("FAIL rmid count before: got %0d want 1", dut.tag_count_q); end
        req_v_i = 2'b10; req_we_i = 2'b10; req_addr_i[AW +: AW] = 28'h700; app_rdy_i = 1'b0;
        #1;
        checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL rmid grant: got %b want 10", req_ready_o); end
        tick();
        req_v_i = 2'b00;
        checks++; if ({app_en_o, app_wdf_wren_o} !== 2'b11) begin errors++; $display("FAIL rmid issuing: got %b want 11", {app_en_o, app_wdf_wren_o}); end
        reset_i = 1'b1;
        tick();
        checks++; if ({app_en_o, app_wdf_wren_o} !== 2'b00) begin errors++; $display("FAIL rmid en/wren after reset: got %b want 00", {app_en_o, app_wdf_wren_o}); end
        checks++; if (dut.tag_count_q !== 4'd0) begin errors++; $display("FAIL rmid count after reset: got %0d want 0", dut.tag_count_q); end
        reset_i = 1'b0; app_rdy_i = 1'b1;
        app_rd_data_valid_i = 1'b1; app_rd_data_i = 128'h99;
        #1;
        checks++; if (resp_v_o !== 2'b00) begin errors++; $display("FAIL rmid stale data: got %b want 00", resp_v_o); end
        tick();
        app_rd_data_valid_i = 1'b0;
        req_v_i = 2'b01; req_we_i = 2'b00;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rmid recovery grant: got %b want 01", req_ready_o); end
        tick();
        req_v_i = 2'b00;
        tick();
        app_rd_data_valid_i = 1'b1;
        #1;
        checks++; if (resp_v_o !== 2'b01) begin errors++; $display("FAIL rmid recovery resp: got %b want 01", resp_v_o); end
        tick();
        app_rd_data_valid_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; init_calib_complete_i = 1'b0;
        req_v_i = '0; req_we_i = '0; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
        app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b1; app_rd_data_i = '0; app_rd_data_valid_i = 1'b0;
        test_reset();
        test_calib();
        test_write();
        test_round_robin();
        test_tag_full();
        test_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
